neuron_layer_sequencer: RTL and testbench



---
 rtl/neuron_layer_sequencer.sv | 135 +++++++++++++
 tb/tb_neuron_layer_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_sequencer.sv
// rtl/neuron_layer_sequencer.sv - layer-pass control FSM driving a shared MAC/activation datapath
module neuron_layer_sequencer #(
  parameter int NUM_NEURONS = 4,
  parameter int VECTOR_LEN  = 4,
  parameter int NIDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  parameter int VIDX_W      = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1,
  parameter int ADDR_W      = (NUM_NEURONS * VECTOR_LEN > 1) ? $clog2(NUM_NEURONS * VECTOR_LEN) : 1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_mac_clear,
  output logic              o_mac_en,
  output logic              o_act_en,
  output logic [VIDX_W-1:0] o_vector_index,
  output logic [NIDX_W-1:0] o_neuron_index,
  output logic [ADDR_W-1:0] o_weight_addr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_ACT   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(VECTOR_LEN - 1);
  localparam logic [NIDX_W-1:0] LAST_N = NIDX_W'(NUM_NEURONS - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [VIDX_W-1:0] r_vidx;
  logic [VIDX_W-1:0] w_vidx_next;
  logic [NIDX_W-1:0] r_nidx;
  logic [NIDX_W-1:0] w_nidx_next;
  logic              r_done;
  logic              w_done_next;

  // State, index counters and the registered done pulse
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_vidx  <= '0;
      r_nidx  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_vidx  <= w_vidx_next;
      r_nidx  <= w_nidx_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state/index logic and state-decoded datapath strobes; abort overrides everything
  always_comb begin
    w_state_next = r_state;
    w_vidx_next  = r_vidx;
    w_nidx_next  = r_nidx;
    w_done_next  = 1'b0;
    o_in_ready   = 1'b0;
    o_mac_clear  = 1'b0;
    o_mac_en     = 1'b0;
    o_act_en     = 1'b0;
    o_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_CLEAR;
          w_vidx_next  = '0;
          w_nidx_next  = '0;
        end
      end
      S_CLEAR: begin
        o_mac_clear  = 1'b1;
        w_vidx_next  = '0;
        w_state_next = S_ACCUM;
      end
      S_ACCUM: begin
        o_in_ready = 1'b1;
        o_mac_en   = i_in_valid;
        if (i_in_valid) begin
          if (r_vidx == LAST_V) begin
            w_vidx_next  = '0;
            w_state_next = S_ACT;
          end else begin
            w_vidx_next = r_vidx + VIDX_W'(1);
          end
        end
      end
      S_ACT: begin
        o_act_en     = 1'b1;
        w_state_next = S_OUT;
      end
      S_OUT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          if (r_nidx == LAST_N) begin
            w_nidx_next  = '0;
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_nidx_next  = r_nidx + NIDX_W'(1);
            w_state_next = S_CLEAR;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_vidx_next  = '0;
        w_nidx_next  = '0;
      end
    endcase
    if (i_abort) begin
      w_state_next = S_IDLE;
      w_vidx_next  = '0;
      w_nidx_next  = '0;
      w_done_next  = 1'b0;
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_vector_index = r_vidx;
  assign o_neuron_index = r_nidx;
  assign o_weight_addr  = ADDR_W'(r_nidx) * ADDR_W'(VECTOR_LEN) + ADDR_W'(r_vidx);

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb/tb_neuron_layer_sequencer.sv - randomized self-checking bench for neuron_layer_sequencer
module tb_neuron_layer_sequencer;

  localparam int N = 4;
  localparam int V = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, mac_clear, mac_en, act_en, out_valid, busy, done;
  logic [1:0] vector_index;
  logic [1:0] neuron_index;
  logic [3:0] weight_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  neuron_layer_sequencer #(.NUM_NEURONS(N), .VECTOR_LEN(V)) u_dut (
    .i_clock        (clock),
    .i_reset_n      (reset_n),
    .i_start        (start),
    .i_abort        (abort),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .o_mac_clear    (mac_clear),
    .o_mac_en       (mac_en),
    .o_act_en       (act_en),
    .o_vector_index (vector_index),
    .o_neuron_index (neuron_index),
    .o_weight_addr  (weight_addr),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_busy         (busy),
    .o_done         (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: random in_valid/out_ready with given percentages
  // mode 1: in_valid alternates every cycle, out_ready always 1
  // mode 2: in_valid/out_ready 1, except out_ready held 0 for 5 cycles at neuron 1
  task automatic run_pass(input string name, input int mode, input int pv, input int pr);
    int exp_addr = 0;
    int clears = 0;
    int acts = 0;
    int outs = 0;
    int stalls = 0;
    int hold = 0;
    int e_en = 0;
    int e_addr = 0;
    int e_wa = 0;
    int e_idx = 0;
    int e_busy = 0;
    int done_edge = -1;
    int c = 1;
    bit got_done = 1'b0;
    @(negedge clock);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    while (!got_done && c <= 3000) begin
      if (mode == 1) in_valid = (c % 2) == 0;
      else if (mode == 2) in_valid = 1'b1;
      else in_valid = $urandom_range(0, 99) < pv;
      #1;
      if (done) begin
        got_done  = 1'b1;
        done_edge = c - 1;
      end else if (!busy) begin
        e_busy++;
      end
      if (weight_addr !== 4'(neuron_index * V + vector_index)) e_wa++;
      if (mac_en !== (in_ready & in_valid)) e_en++;
      if (mac_clear) clears++;
      if (act_en) acts++;
      if (in_ready) begin
        if (in_valid) begin
          if (weight_addr !== 4'(exp_addr)) e_addr++;
          exp_addr++;
        end else begin
          stalls++;
        end
      end
      out_ready = 1'b1;
      if (out_valid) begin
        if (neuron_index !== 2'(outs)) e_idx++;
        if (mode == 2) begin
          if (neuron_index == 2'd1 && hold < 5) begin
            out_ready = 1'b0;
            hold++;
          end
        end else if (mode == 0) begin
          out_ready = $urandom_range(0, 99) < pr;
        end
        if (out_ready) outs++;
        else stalls++;
      end
      start = busy && ($urandom_range(0, 3) == 0);
      c++;
      if (!got_done) @(negedge clock);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check({name, "_done_seen"}, 32'(got_done), 1);
    check({name, "_latency"}, done_edge, N * (V + 3) + stalls);
    check({name, "_mac_clears"}, clears, N);
    check({name, "_mac_accepts"}, exp_addr, N * V);
    check({name, "_act_pulses"}, acts, N);
    check({name, "_out_handshakes"}, outs, N);
    check({name, "_addr_order_errs"}, e_addr, 0);
    check({name, "_mac_en_errs"}, e_en, 0);
    check({name, "_weight_addr_errs"}, e_wa, 0);
    check({name, "_out_index_errs"}, e_idx, 0);
    check({name, "_busy_errs"}, e_busy, 0);
    if (mode == 2) check({name, "_hold_cycles"}, hold, 5);
    @(negedge clock);
    #1;
    check({name, "_done_one_cycle"}, 32'(done), 0);
    check({name, "_idle_after"}, 32'(busy), 0);
  endtask

  task automatic wait_for_pos(input string name, input int n, input int v);
    int w = 0;
    while (!(neuron_index == 2'(n) && vector_index == 2'(v) && in_ready) && w < 200) begin
      @(negedge clock);
      w++;
    end
    check({name, "_reached"}, 32'(w < 200), 1);
  endtask

  initial begin
    int dn;
    // reset state
    #2;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_strobes", {25'd0, in_ready, mac_clear, mac_en, act_en, out_valid, 2'd0}, 0);
    check("reset_indices", {28'd0, neuron_index, vector_index}, 0);
    check("reset_weight_addr", weight_addr, 0);
    @(negedge clock);
    reset_n = 1'b1;

    run_pass("nostall", 0, 100, 100);
    run_pass("alt_valid", 1, 0, 100);
    run_pass("out_hold", 2, 100, 100);
    for (int i = 0; i < 4; i++) run_pass("random", 0, $urandom_range(30, 90), $urandom_range(30, 90));

    // abort mid-accumulate at neuron 2, element 1
    @(negedge clock);
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_for_pos("abort", 2, 1);
    abort = 1'b1;
    #1;
    check("abort_in_ready_same_cycle", 32'(in_ready), 1);
    @(negedge clock);
    abort = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_indices", {28'd0, neuron_index, vector_index}, 0);
    check("abort_in_ready", 32'(in_ready), 0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #1;
      if (done || busy) dn++;
    end
    check("abort_no_done_or_restart", dn, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    run_pass("replay", 0, 100, 100);

    // start and abort together in IDLE
    @(negedge clock);
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    #1;
    check("start_abort_busy", 32'(busy), 0);
    check("start_abort_clear", 32'(mac_clear), 0);
    check("start_abort_indices", {28'd0, neuron_index, vector_index}, 0);

    // asynchronous reset with indices mid-count (neuron 2, element 3)
    @(negedge clock);
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_for_pos("rst_mid", 2, 3);
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_indices", {28'd0, neuron_index, vector_index}, 0);
    check("rst_mid_weight_addr", weight_addr, 0);
    check("rst_mid_in_ready", 32'(in_ready), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    check("rst_no_resume", 32'(busy), 0);
    in_valid = 1'b0; out_ready = 1'b0;
    run_pass("post_reset", 0, 70, 70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
